// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Holds the sequencer state encoding and reference truth tables for 2-input gates.
// Truth-table bit k is the expected gate output for input vector k.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } gate_chk_state_e;

    // Bit k = expected output when stim == k (stim bit 0 is input a).
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/gate_chk_hold_timer.sv
// Purpose: per-vector hold counter; pulses tc_o on the last cycle of each hold window.
// Latency: tc_o is combinational from the registered count, asserted HOLD_CYCLES cycles after load.
// Backpressure: none; counts only while en_i is high and wraps to 0 after the terminal cycle.
module gate_chk_hold_timer
    import gate_chk_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count is only meaningful while the sequencer is driving.
    assign tc_o = en_i && (cnt_q == CNT_LAST);

    // Next count: restart on load, wrap after the terminal cycle, else increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_tt_checker.sv
// Purpose: walks every input vector onto a gate, checks each response against EXPECT, reports results.
// Latency: done rises 2^N_IN*HOLD_CYCLES+1 cycles after start; dut_y sampled on each hold's last cycle.
// Backpressure: none; start is ignored while busy. Macro GATE_CHK_STOP_ON_ERR_EN ends the run on first mismatch.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter int                   N_IN        = 2,
    parameter int                   HOLD_CYCLES = 10,
    parameter logic [2**N_IN-1:0]   EXPECT      = TT_OR2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx
);

    // Index carries one extra bit so the terminal compare never sees a wrapped value.
    localparam int IDX_W = N_IN + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << N_IN) - 1);

`ifdef GATE_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    gate_chk_state_e  state_q;
    logic [IDX_W-1:0] idx_q;
    logic [N_IN-1:0]  stim_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [N_IN:0]    err_q;
    logic [N_IN-1:0]  first_q;

    logic             start_ok;
    logic             hold_tc;
    logic             mismatch;
    logic             idx_is_last;
    logic [IDX_W-1:0] idx_d;
    logic [N_IN:0]    err_d;

    assign start_ok = start && (state_q != ST_DRIVE);

    gate_chk_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_ok),
        .en_i   (state_q == ST_DRIVE),
        .tc_o   (hold_tc)
    );

    // Response check and next-index arithmetic for the vector currently on stim.
    always_comb begin
        mismatch    = (dut_y != EXPECT[idx_q[N_IN-1:0]]);
        idx_is_last = (idx_q == IDX_LAST);
        idx_d       = idx_q + IDX_W'(1);
        err_d       = err_q + {{N_IN{1'b0}}, mismatch};
    end

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_DRIVE;
                        idx_q   <= '0;
                        stim_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (hold_tc) begin
                        err_q <= err_d;
                        if (mismatch && (err_q == '0)) begin
                            first_q <= idx_q[N_IN-1:0];
                        end
                        if ((STOP_ON_ERR && mismatch) || idx_is_last) begin
                            // stim is left on the last (or failing) vector.
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            idx_q  <= idx_d;
                            stim_q <= idx_d[N_IN-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim          = stim_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: OR gate, stuck-at-0 gate, mid-run reset,
// ignored re-starts, and a HOLD_CYCLES=1 instance run twice back to back.
module tb_gate_tt_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       stuck = 1'b0;

    logic [1:0] stim1, stim2;
    logic       y1, y2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [2:0] err1, err2;
    logic [1:0] first1, first2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Gate models: OR gate, optionally stuck at 0.
    assign y1 = stuck ? 1'b0 : (stim1[0] | stim1[1]);
    assign y2 = stim2[0] | stim2[1];

    gate_tt_checker #(.N_IN(2), .HOLD_CYCLES(10), .EXPECT(TT_OR2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stim(stim1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_idx(first1)
    );

    gate_tt_checker #(.N_IN(2), .HOLD_CYCLES(1), .EXPECT(TT_OR2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stim(stim2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(first2)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut1_zero(input string tag);
        check_val({tag, " stim"},  int'(stim1),  0);
        check_val({tag, " busy"},  int'(busy1),  0);
        check_val({tag, " done"},  int'(done1),  0);
        check_val({tag, " pass"},  int'(pass1),  0);
        check_val({tag, " err"},   int'(err1),   0);
        check_val({tag, " first"}, int'(first1), 0);
    endtask

    // Called at a negedge. Pulses start so edge 0 samples it, then walks cycles
    // 1..done_cyc checking stim per vector and the final result.
    task automatic run_dut1(input string tag, input int done_cyc, input int exp_err,
                            input int exp_first, input int exp_stim, input bit repulse);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= done_cyc; c++) begin
            if (repulse && (c == 5 || c == 20)) start1 = 1'b1;
            if (repulse && (c == 6 || c == 21)) start1 = 1'b0;
            if (c == 1) check_val({tag, " busy@1"}, int'(busy1), 1);
            if (c < done_cyc && (((c - 1) % 10) == 0 || (c % 10) == 0))
                check_val($sformatf("%s stim@%0d", tag, c), int'(stim1), (c - 1) / 10);
            if (c == done_cyc - 1) check_val({tag, " done-early"}, int'(done1), 0);
            if (c == done_cyc) begin
                check_val({tag, " done"},  int'(done1),  1);
                check_val({tag, " busy"},  int'(busy1),  0);
                check_val({tag, " pass"},  int'(pass1),  (exp_err == 0) ? 1 : 0);
                check_val({tag, " err"},   int'(err1),   exp_err);
                check_val({tag, " first"}, int'(first1), exp_first);
                check_val({tag, " stim"},  int'(stim1),  exp_stim);
            end else begin
                @(negedge clk);
            end
        end
        start1 = 1'b0;
    endtask

    task automatic run_dut2(input string tag);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) begin
                check_val($sformatf("%s stim@%0d", tag, c), int'(stim2), c - 1);
                check_val($sformatf("%s done@%0d", tag, c), int'(done2), 0);
            end else begin
                check_val({tag, " done"}, int'(done2), 1);
                check_val({tag, " pass"}, int'(pass2), 1);
                check_val({tag, " err"},  int'(err2),  0);
                check_val({tag, " stim"}, int'(stim2), 3);
            end
            if (c < 5) @(negedge clk);
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check_dut1_zero("reset");
        check_val("reset busy2", int'(busy2), 0);
        rst = 1'b0;
        @(negedge clk);

        // Passing OR run
        run_dut1("or", 41, 0, 0, 3, 1'b0);
        @(negedge clk);

        // Stuck-at-0 gate
        stuck = 1'b1;
`ifdef GATE_CHK_STOP_ON_ERR_EN
        run_dut1("stuck", 21, 1, 1, 1, 1'b0);
`else
        run_dut1("stuck", 41, 3, 1, 3, 1'b0);
`endif
        stuck = 1'b0;
        @(negedge clk);
        check_val("done held", int'(done1), 1);

        // Mid-run reset: start at edge 0, reset sampled at edge 15
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (14) @(negedge clk);
        check_val("midrun busy@15", int'(busy1), 1);
        check_val("midrun stim@15", int'(stim1), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_dut1_zero("midrun rst@16");
        run_dut1("after-rst", 41, 0, 0, 3, 1'b0);
        @(negedge clk);

        // Re-start pulses during DRIVE are ignored
        run_dut1("repulse", 41, 0, 0, 3, 1'b1);
        @(negedge clk);

        // Reset and start together: reset wins
        rst = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start1 = 1'b0;
        check_dut1_zero("rst+start");
        @(negedge clk);
        check_val("rst+start idle", int'(busy1), 0);

        // HOLD_CYCLES=1 instance, twice back to back from DONE
        run_dut2("h1 run1");
        @(negedge clk);
        run_dut2("h1 run2");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
